rr_req_gnt_arbiter: RTL and testbench
=====================================

Name: rr_req_gnt_arbiter

Overview:
- Round-robin arbiter sharing one req/gnt resource among N_REQ requesters.
- Grants one requester at a time and holds the grant while that requester keeps req high.
- Forces release after MAX_HOLD grant cycles.
- Sits in front of the shared req/gnt resource. Its outputs follow the same req->gnt timing the team's bound assertion modules check (grant one cycle after sampled request).

Parameters:
- N_REQ, 4: number of requesters, 2..16.
- MAX_HOLD, 8: maximum consecutive grant cycles per ownership. 0 disables the timeout.
- ID_W, $clog2(N_REQ): width of gnt_id. Derived localparam; do not override.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset (0 = reset asserted)
- req  in  N_REQ  level request per requester
- gnt  out  N_REQ  one-hot grant, registered
- gnt_id  out  ID_W  index of current owner; valid only when busy=1
- busy  out  1  1 while any gnt bit is set
- timeout  out  1  single-cycle pulse when a grant is force-released

Behaviour:
- Reset (reset=0, asynchronous): gnt=0, gnt_id=0, busy=0, timeout=0, state=IDLE, rr pointer=0, hold_cnt=0. All outputs are registered; there are no combinational paths from req to any output.
- States:
  - IDLE: no owner. If req != 0 at a rising edge, pick the first set bit searching upward from the pointer, wrapping modulo N_REQ. On that edge: set gnt[w], gnt_id=w, busy=1, hold_cnt=1, go to GRANT. If req == 0, stay in IDLE.
  - GRANT:
    - If req[owner]=1 and (MAX_HOLD==0 or hold_cnt<MAX_HOLD): stay; hold_cnt++ (saturating when MAX_HOLD==0).
    - If req[owner]=0: clear gnt and busy; pointer=owner+1 mod N_REQ; go to GAP.
    - If req[owner]=1 and hold_cnt==MAX_HOLD (MAX_HOLD!=0): clear gnt and busy, assert timeout for one cycle, pointer=owner+1 mod N_REQ, go to GAP.
  - GAP: exactly one cycle with gnt=0, then go to IDLE. Requests are not sampled in GAP.
- Latency:
  - Request sampled in IDLE -> gnt visible 1 cycle later.
  - Release -> next grant visible no earlier than 2 cycles after gnt falls (GAP cycle, then the IDLE arbitration edge).
- Requests from non-owners are ignored during GRANT and GAP. Requesters are not required to hold req, but a request that drops before IDLE samples it is lost.
- Owner drops req on the same edge that hold_cnt reaches MAX_HOLD: treated as a normal release; timeout stays 0.
- MAX_HOLD=1: every grant lasts exactly 1 cycle; timeout pulses whenever the owner still requests.
- Single persistent requester: it is re-granted after each GAP. Fairness comes only from pointer rotation.
- Pointer wrap: owner N_REQ-1 -> pointer 0.
- Reset asserted mid-grant: gnt drops immediately (asynchronously). After reset deasserts, arbitration restarts from pointer 0.
- Invariants: gnt is zero or one-hot; busy == |gnt; gnt_id == index of the set gnt bit whenever busy=1.

Optional Feature:
- Macro: RR_ARB_ASSERT_EN.
- When defined, the block includes internal concurrent assertions, disabled while reset=0:
  - gnt is $onehot0.
  - A gnt bit is never set unless the same req bit was 1 on the previous edge.
  - timeout implies gnt==0 in the next cycle.
  - A grant never lasts longer than MAX_HOLD cycles.
  - Each assertion reports a failure with $error, giving the simulation time.
- When undefined, no assertion code is compiled and behaviour is identical.

Decomposition:
- Package rr_arb_pkg: state enum (IDLE, GRANT, GAP) as a 2-bit typedef, and a default N_REQ constant.
- Sub-module rr_pick: purely combinational; inputs req and pointer, outputs found and winner index. It rotates, runs a priority search, and un-rotates.
- The parent holds the FSM, hold_cnt, pointer and output registers.

Test Plan:
- Reset then req=4'b0001 held 3 cycles, then dropped -> gnt=0001 from cycle 1 through 3, busy=1, gnt_id=0; gnt=0 in cycle 4; pointer=1.
- req=4'b1111 held continuously, MAX_HOLD=8 -> grants go to 0,1,2,3,0 in order. Each grant lasts 8 cycles followed by one GAP cycle, and timeout pulses at the end of each grant.
- req=4'b1000 with pointer=3 dropped on the exact MAX_HOLD edge -> normal release, timeout=0; next grant goes to 0 if req[0] is set.
- MAX_HOLD=0, req=0010 held 100 cycles -> gnt=0010 for all 100 cycles, timeout never asserts.
- reset driven 0 mid-grant (gnt=0100) -> gnt=0, busy=0 immediately without waiting for a clock. After reset releases, req=0110 -> gnt=0010 (pointer back at 0).
- Stress: random req for 10k cycles with RR_ARB_ASSERT_EN defined -> no assertion failures; every continuously-requesting requester is granted within N_REQ*(MAX_HOLD+2) cycles.

Source files
------------

// File: rtl/rr_arb_pkg.sv
// Shared types and defaults for the round-robin req/gnt arbiter.
package rr_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } arb_state_e;

  localparam int unsigned RR_N_REQ_DEFAULT = 4;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or above the pointer,
// wrapping modulo N_REQ.
module rr_pick import rr_arb_pkg::*; #(
  parameter  int unsigned N_REQ = RR_N_REQ_DEFAULT,
  localparam int unsigned ID_W  = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [ID_W-1:0]  ptr_i,
  output logic             found_o,
  output logic [ID_W-1:0]  winner_o
);

  localparam logic [ID_W:0] N_W = (ID_W+1)'(N_REQ);

  logic [2*N_REQ-1:0] dbl;
  logic [N_REQ-1:0]   rot;
  logic [ID_W-1:0]    idx;
  logic [ID_W:0]      sum;

  // Rotating the doubled vector puts the pointer position at bit 0.
  assign dbl = {req_i, req_i} >> ptr_i;
  assign rot = dbl[N_REQ-1:0];

  always_comb begin
    found_o = 1'b0;
    idx     = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (!found_o && rot[i]) begin
        found_o = 1'b1;
        idx     = ID_W'(i);
      end
    end
  end

  always_comb begin
    sum      = {1'b0, idx} + {1'b0, ptr_i};
    winner_o = (sum >= N_W) ? ID_W'(sum - N_W) : sum[ID_W-1:0];
  end

endmodule

// File: rtl/rr_req_gnt_arbiter.sv
// Round-robin req/gnt arbiter with hold timeout and a one-cycle gap between owners.
// Optional internal assertions are compiled when RR_ARB_ASSERT_EN is defined.
module rr_req_gnt_arbiter import rr_arb_pkg::*; #(
  parameter  int unsigned N_REQ    = RR_N_REQ_DEFAULT,
  parameter  int unsigned MAX_HOLD = 8,
  localparam int unsigned ID_W     = $clog2(N_REQ)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] gnt,
  output logic [ID_W-1:0]  gnt_id,
  output logic             busy,
  output logic             timeout
);

  localparam int unsigned   HC_W     = (MAX_HOLD < 2) ? 1 : $clog2(MAX_HOLD + 1);
  localparam logic [HC_W-1:0] HOLD_MAX = HC_W'(MAX_HOLD);
  localparam logic [ID_W:0]   N_W      = (ID_W+1)'(N_REQ);

  arb_state_e        state_q, state_d;
  logic [ID_W-1:0]   ptr_q, ptr_d;
  logic [HC_W-1:0]   hold_q, hold_d;
  logic [N_REQ-1:0]  gnt_q, gnt_d;
  logic [ID_W-1:0]   id_q, id_d;
  logic              busy_q, busy_d;
  logic              to_q, to_d;

  logic              found;
  logic [ID_W-1:0]   winner;
  logic [ID_W:0]     ptr_sum;
  logic [ID_W-1:0]   ptr_inc;
  logic              owner_req;

  rr_pick #(.N_REQ(N_REQ)) u_pick (
    .req_i    (req),
    .ptr_i    (ptr_q),
    .found_o  (found),
    .winner_o (winner)
  );

  assign ptr_sum   = {1'b0, id_q} + (ID_W+1)'(1);
  assign ptr_inc   = (ptr_sum == N_W) ? '0 : ptr_sum[ID_W-1:0];
  assign owner_req = req[id_q];

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    hold_d  = hold_q;
    gnt_d   = gnt_q;
    id_d    = id_q;
    busy_d  = busy_q;
    to_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (found) begin
          gnt_d   = N_REQ'(1) << winner;
          id_d    = winner;
          busy_d  = 1'b1;
          hold_d  = HC_W'(1);
          state_d = GRANT;
        end
      end
      GRANT: begin
        if (owner_req && (MAX_HOLD == 0 || hold_q < HOLD_MAX)) begin
          if (hold_q != '1) hold_d = hold_q + HC_W'(1);
        end else begin
          // Owner drop takes priority, so a drop on the limit edge is a plain release.
          to_d    = owner_req;
          gnt_d   = '0;
          busy_d  = 1'b0;
          hold_d  = '0;
          ptr_d   = ptr_inc;
          state_d = GAP;
        end
      end
      GAP:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      hold_q  <= '0;
      gnt_q   <= '0;
      id_q    <= '0;
      busy_q  <= 1'b0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      hold_q  <= hold_d;
      gnt_q   <= gnt_d;
      id_q    <= id_d;
      busy_q  <= busy_d;
      to_q    <= to_d;
    end
  end

  assign gnt     = gnt_q;
  assign gnt_id  = id_q;
  assign busy    = busy_q;
  assign timeout = to_q;

`ifdef RR_ARB_ASSERT_EN
  logic [HC_W:0] run_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)      run_q <= '0;
    else if (busy_q) run_q <= (run_q != '1) ? run_q + (HC_W+1)'(1) : run_q;
    else             run_q <= '0;
  end

  a_onehot: assert property (@(posedge clk) disable iff (!reset) $onehot0(gnt_q))
    else $error("rr_req_gnt_arbiter: gnt not onehot0 at %0t", $time);

  a_gnt_req: assert property (@(posedge clk) disable iff (!reset)
                              (gnt_q & ~$past(req)) == '0)
    else $error("rr_req_gnt_arbiter: gnt without prior req at %0t", $time);

  a_to_clear: assert property (@(posedge clk) disable iff (!reset) to_q |=> (gnt_q == '0))
    else $error("rr_req_gnt_arbiter: gnt set after timeout at %0t", $time);

  a_max_hold: assert property (@(posedge clk) disable iff (!reset)
                               (MAX_HOLD == 0) || (run_q <= (HC_W+1)'(MAX_HOLD)))
    else $error("rr_req_gnt_arbiter: grant exceeded MAX_HOLD at %0t", $time);
`else
`endif

endmodule

// File: tb/tb_rr_req_gnt_arbiter.sv
// Directed self-checking bench for rr_req_gnt_arbiter (MAX_HOLD 8, 0 and 1 instances).
module tb_rr_req_gnt_arbiter;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] req_a = '0, req_z = '0, req_o = '0;
  logic [3:0] gnt_a, gnt_z, gnt_o;
  logic [1:0] id_a, id_z, id_o;
  logic       busy_a, busy_z, busy_o;
  logic       to_a, to_z, to_o;

  int unsigned errors = 0;
  int unsigned checks = 0;

  always #5 clk = ~clk;

  rr_req_gnt_arbiter #(.N_REQ(4), .MAX_HOLD(8)) dut (
    .clk(clk), .reset(reset), .req(req_a), .gnt(gnt_a),
    .gnt_id(id_a), .busy(busy_a), .timeout(to_a));

  rr_req_gnt_arbiter #(.N_REQ(4), .MAX_HOLD(0)) dut_z (
    .clk(clk), .reset(reset), .req(req_z), .gnt(gnt_z),
    .gnt_id(id_z), .busy(busy_z), .timeout(to_z));

  rr_req_gnt_arbiter #(.N_REQ(4), .MAX_HOLD(1)) dut_o (
    .clk(clk), .reset(reset), .req(req_o), .gnt(gnt_o),
    .gnt_id(id_o), .busy(busy_o), .timeout(to_o));

  typedef struct {
    logic [3:0] req;
    logic [3:0] gnt;
    logic [1:0] id;
    logic       busy;
    logic       to;
  } vec_t;

  vec_t tbl [23];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    req_a = '0; req_z = '0; req_o = '0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  initial begin
    int unsigned wait0;

    // {req, expected gnt, id, busy, timeout}, one row per clock from reset (pointer 0)
    tbl[0]  = '{4'b0001, 4'b0001, 2'd0, 1'b1, 1'b0};
    tbl[1]  = '{4'b0001, 4'b0001, 2'd0, 1'b1, 1'b0};
    tbl[2]  = '{4'b0001, 4'b0001, 2'd0, 1'b1, 1'b0};
    tbl[3]  = '{4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0};
    tbl[4]  = '{4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0};
    tbl[5]  = '{4'b0101, 4'b0100, 2'd2, 1'b1, 1'b0};
    tbl[6]  = '{4'b0001, 4'b0000, 2'd0, 1'b0, 1'b0};
    tbl[7]  = '{4'b0001, 4'b0000, 2'd0, 1'b0, 1'b0};
    tbl[8]  = '{4'b0001, 4'b0001, 2'd0, 1'b1, 1'b0};
    tbl[9]  = '{4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0};
    tbl[10] = '{4'b1010, 4'b0000, 2'd0, 1'b0, 1'b0};
    tbl[11] = '{4'b1010, 4'b0010, 2'd1, 1'b1, 1'b0};
    tbl[12] = '{4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0};
    tbl[13] = '{4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0};
    tbl[14] = '{4'b1000, 4'b1000, 2'd3, 1'b1, 1'b0};
    tbl[15] = '{4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0};
    tbl[16] = '{4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0};
    tbl[17] = '{4'b0110, 4'b0010, 2'd1, 1'b1, 1'b0};
    tbl[18] = '{4'b0110, 4'b0010, 2'd1, 1'b1, 1'b0};
    tbl[19] = '{4'b0100, 4'b0000, 2'd0, 1'b0, 1'b0};
    tbl[20] = '{4'b0100, 4'b0000, 2'd0, 1'b0, 1'b0};
    tbl[21] = '{4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0};
    tbl[22] = '{4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0};

    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_gnt", gnt_a, 4'b0000);
    chk("rst_id", id_a, 2'd0);
    chk("rst_busy", busy_a, 1'b0);
    chk("rst_timeout", to_a, 1'b0);
    reset = 1'b1;

    for (int unsigned i = 0; i < 23; i++) begin
      req_a = tbl[i].req;
      step();
      chk($sformatf("tbl%0d_gnt", i), gnt_a, tbl[i].gnt);
      chk($sformatf("tbl%0d_busy", i), busy_a, tbl[i].busy);
      chk($sformatf("tbl%0d_timeout", i), to_a, tbl[i].to);
      if (tbl[i].busy) chk($sformatf("tbl%0d_id", i), id_a, tbl[i].id);
    end

    // All four requesting: 8-cycle grants in order 0,1,2,3,0, timeout in the GAP cycle
    do_reset();
    req_a = 4'b1111;
    for (int unsigned k = 0; k < 5; k++) begin
      for (int unsigned c = 0; c < 8; c++) begin
        step();
        chk($sformatf("rr%0d_c%0d_gnt", k, c), gnt_a, 4'b0001 << (k % 4));
        chk($sformatf("rr%0d_c%0d_id", k, c), id_a, k % 4);
        chk($sformatf("rr%0d_c%0d_timeout", k, c), to_a, 1'b0);
      end
      step();
      chk($sformatf("rr%0d_gap_gnt", k), gnt_a, 4'b0000);
      chk($sformatf("rr%0d_gap_timeout", k), to_a, 1'b1);
      step();
      chk($sformatf("rr%0d_idle_gnt", k), gnt_a, 4'b0000);
      chk($sformatf("rr%0d_idle_timeout", k), to_a, 1'b0);
    end

    // Owner 3 drops on the exact MAX_HOLD edge: normal release, then wrap to 0
    do_reset();
    req_a = 4'b0100;
    step();
    chk("ptr3_setup_gnt", gnt_a, 4'b0100);
    req_a = 4'b0000;
    step();
    step();
    req_a = 4'b1000;
    for (int unsigned c = 0; c < 8; c++) begin
      step();
      chk($sformatf("edge_c%0d_gnt", c), gnt_a, 4'b1000);
      chk($sformatf("edge_c%0d_id", c), id_a, 2'd3);
    end
    req_a = 4'b0001;
    step();
    chk("edge_rel_gnt", gnt_a, 4'b0000);
    chk("edge_rel_timeout", to_a, 1'b0);
    step();
    chk("edge_gap_timeout", to_a, 1'b0);
    step();
    chk("edge_next_gnt", gnt_a, 4'b0001);
    chk("edge_next_id", id_a, 2'd0);

    // MAX_HOLD=0: a persistent owner keeps the grant indefinitely
    do_reset();
    req_z = 4'b0010;
    for (int unsigned c = 0; c < 100; c++) begin
      step();
      chk($sformatf("nohold_c%0d_gnt", c), gnt_z, 4'b0010);
      chk($sformatf("nohold_c%0d_timeout", c), to_z, 1'b0);
    end

    // MAX_HOLD=1: single-cycle grants with timeout while still requested
    do_reset();
    req_o = 4'b0011;
    step();
    chk("hold1_g0_gnt", gnt_o, 4'b0001);
    step();
    chk("hold1_rel_gnt", gnt_o, 4'b0000);
    chk("hold1_rel_timeout", to_o, 1'b1);
    step();
    chk("hold1_idle_timeout", to_o, 1'b0);
    step();
    chk("hold1_g1_gnt", gnt_o, 4'b0010);
    chk("hold1_g1_id", id_o, 2'd1);

    // Asynchronous reset mid-grant, then restart from pointer 0
    do_reset();
    req_a = 4'b0100;
    step();
    chk("mid_pre_gnt", gnt_a, 4'b0100);
    #2;
    reset = 1'b0;
    #1;
    chk("mid_async_gnt", gnt_a, 4'b0000);
    chk("mid_async_busy", busy_a, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    req_a = 4'b0110;
    step();
    chk("mid_after_gnt", gnt_a, 4'b0010);
    chk("mid_after_id", id_a, 2'd1);

    // Random traffic with requester 0 always asserting: invariants and bounded wait
    do_reset();
    wait0 = 0;
    for (int unsigned c = 0; c < 3000; c++) begin
      req_a = {3'($urandom), 1'b1};
      step();
      chk("rnd_onehot0", ($countones(gnt_a) <= 1), 1'b1);
      chk("rnd_busy", busy_a, |gnt_a);
      if (busy_a) chk("rnd_id", gnt_a[id_a], 1'b1);
      if (gnt_a[0]) wait0 = 0;
      else wait0++;
      chk("rnd_fair_wait", (wait0 <= 4 * (8 + 2)), 1'b1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
